// File: rtl/icache_mem_initiator.sv
// Instruction-cache miss initiator: accepts MSHR misses, issues line-aligned memory
// fetches, tracks in-flight tags and forwards matched responses as refills.
module icache_mem_initiator #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 256,
    parameter int ID_WIDTH          = 8,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int LINE_OFFSET_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 miss_vld,
    output logic                                 miss_rdy,
    input  logic [ADDR_WIDTH-1:0]                miss_addr,
    input  logic [ID_WIDTH-1:0]                  miss_id,
    output logic                                 fetch_mem_req_vld,
    input  logic                                 fetch_mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]                fetch_mem_req_addr,
    output logic [ID_WIDTH-1:0]                  fetch_mem_req_entry_id,
    input  logic                                 fetch_mem_ack_vld,
    output logic                                 fetch_mem_ack_rdy,
    input  logic [DATA_WIDTH-1:0]                fetch_mem_ack_data,
    input  logic [ID_WIDTH-1:0]                  fetch_mem_ack_entry_id,
    output logic                                 refill_vld,
    input  logic                                 refill_rdy,
    output logic [DATA_WIDTH-1:0]                refill_data,
    output logic [ID_WIDTH-1:0]                  refill_id,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
    output logic                                 err_unexp_ack
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_OFFSET_WIDTH) - ADDR_WIDTH'(1));

    logic [MAX_OUTSTANDING-1:0] slot_valid_r;
    logic [ID_WIDTH-1:0]        slot_id_r [MAX_OUTSTANDING];
    logic [CNT_W-1:0]           cnt_r;

    logic                       req_vld_r;
    logic [ADDR_WIDTH-1:0]      req_addr_r;
    logic [ID_WIDTH-1:0]        req_id_r;

    logic                       refill_vld_r;
    logic [DATA_WIDTH-1:0]      refill_data_r;
    logic [ID_WIDTH-1:0]        refill_id_r;
    logic                       err_r;

    logic                       id_hit_s;
    logic                       ack_hit_s;
    logic [SLOT_W-1:0]          ack_slot_s;
    logic [SLOT_W-1:0]          alloc_slot_s;
    logic                       alloc_s;
    logic                       ack_acc_s;
    logic                       free_s;

    // Tracker lookup: duplicate-tag check, response match and lowest free slot.
    always_comb begin
        id_hit_s     = 1'b0;
        ack_hit_s    = 1'b0;
        ack_slot_s   = '0;
        alloc_slot_s = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            id_hit_s     = id_hit_s  | (slot_valid_r[i] & (slot_id_r[i] == miss_id));
            ack_hit_s    = ack_hit_s | (slot_valid_r[i] & (slot_id_r[i] == fetch_mem_ack_entry_id));
            ack_slot_s   = (slot_valid_r[i] && (slot_id_r[i] == fetch_mem_ack_entry_id))
                           ? SLOT_W'(i) : ack_slot_s;
            // Descending scan so the last write wins with the lowest free index.
            alloc_slot_s = slot_valid_r[i] ? alloc_slot_s : SLOT_W'(i);
        end
    end

    assign miss_rdy          = (cnt_r < MAX_CNT) && (!req_vld_r || fetch_mem_req_rdy) && !id_hit_s;
    assign fetch_mem_ack_rdy = !refill_vld_r || refill_rdy;
    assign alloc_s           = miss_vld && miss_rdy;
    assign ack_acc_s         = fetch_mem_ack_vld && fetch_mem_ack_rdy;
    assign free_s            = ack_acc_s && ack_hit_s;

    // Tracker slot table: allocate on miss acceptance, release on matched response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                slot_id_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (alloc_s && (alloc_slot_s == SLOT_W'(i))) begin
                    slot_valid_r[i] <= 1'b1;
                    slot_id_r[i]    <= miss_id;
                end else if (free_s && (ack_slot_s == SLOT_W'(i))) begin
                    slot_valid_r[i] <= 1'b0;
                end else begin
                    slot_valid_r[i] <= slot_valid_r[i];
                end
            end
        end
    end

    // In-flight counter; allocate and free in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            case ({alloc_s, free_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Single-stage request register toward memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_vld_r  <= 1'b0;
            req_addr_r <= '0;
            req_id_r   <= '0;
        end else if (alloc_s) begin
            req_vld_r  <= 1'b1;
            req_addr_r <= miss_addr & LINE_MASK;
            req_id_r   <= miss_id;
        end else if (fetch_mem_req_rdy) begin
            req_vld_r  <= 1'b0;
        end else begin
            req_vld_r  <= req_vld_r;
        end
    end

    // Refill output register, loaded only by responses that match a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_vld_r  <= 1'b0;
            refill_data_r <= '0;
            refill_id_r   <= '0;
        end else if (free_s) begin
            refill_vld_r  <= 1'b1;
            refill_data_r <= fetch_mem_ack_data;
            refill_id_r   <= fetch_mem_ack_entry_id;
        end else if (refill_rdy) begin
            refill_vld_r  <= 1'b0;
        end else begin
            refill_vld_r  <= refill_vld_r;
        end
    end

    // One-cycle error pulse for a consumed response with no matching slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= ack_acc_s && !ack_hit_s;
        end
    end

    assign fetch_mem_req_vld      = req_vld_r;
    assign fetch_mem_req_addr     = req_addr_r;
    assign fetch_mem_req_entry_id = req_id_r;
    assign refill_vld             = refill_vld_r;
    assign refill_data            = refill_data_r;
    assign refill_id              = refill_id_r;
    assign outstanding_cnt        = cnt_r;
    assign err_unexp_ack          = err_r;

endmodule

// File: tb/tb_icache_mem_initiator.sv
// Scoreboard bench for icache_mem_initiator: expected requests/refills queued at
// stimulus time and compared when the DUT hands them over.
module tb_icache_mem_initiator;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_vld;
    logic         miss_rdy;
    logic [31:0]  miss_addr;
    logic [7:0]   miss_id;
    logic         fetch_mem_req_vld;
    logic         fetch_mem_req_rdy;
    logic [31:0]  fetch_mem_req_addr;
    logic [7:0]   fetch_mem_req_entry_id;
    logic         fetch_mem_ack_vld;
    logic         fetch_mem_ack_rdy;
    logic [255:0] fetch_mem_ack_data;
    logic [7:0]   fetch_mem_ack_entry_id;
    logic         refill_vld;
    logic         refill_rdy;
    logic [255:0] refill_data;
    logic [7:0]   refill_id;
    logic [2:0]   outstanding_cnt;
    logic         err_unexp_ack;

    typedef struct packed { logic [31:0] addr; logic [7:0] id; } req_t;
    typedef struct packed { logic [255:0] data; logic [7:0] id; } refill_t;

    req_t    req_q[$];
    refill_t refill_q[$];
    int      checks   = 0;
    int      failures = 0;
    int      err_seen = 0;
    int      err_exp  = 0;
    logic [255:0] d_hold;

    icache_mem_initiator dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_vld               (miss_vld),
        .miss_rdy               (miss_rdy),
        .miss_addr              (miss_addr),
        .miss_id                (miss_id),
        .fetch_mem_req_vld      (fetch_mem_req_vld),
        .fetch_mem_req_rdy      (fetch_mem_req_rdy),
        .fetch_mem_req_addr     (fetch_mem_req_addr),
        .fetch_mem_req_entry_id (fetch_mem_req_entry_id),
        .fetch_mem_ack_vld      (fetch_mem_ack_vld),
        .fetch_mem_ack_rdy      (fetch_mem_ack_rdy),
        .fetch_mem_ack_data     (fetch_mem_ack_data),
        .fetch_mem_ack_entry_id (fetch_mem_ack_entry_id),
        .refill_vld             (refill_vld),
        .refill_rdy             (refill_rdy),
        .refill_data            (refill_data),
        .refill_id              (refill_id),
        .outstanding_cnt        (outstanding_cnt),
        .err_unexp_ack          (err_unexp_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: compare transfers at the falling edge, ahead of the accepting rising edge.
    always @(negedge clk) begin
        if (rst_n && fetch_mem_req_vld && fetch_mem_req_rdy) begin
            if (req_q.size() == 0) begin
                check_eq("req_unexpected", 256'(req_q.size()), 256'(1));
            end else begin
                req_t r;
                r = req_q.pop_front();
                check_eq("req_addr", 256'(fetch_mem_req_addr), 256'(r.addr));
                check_eq("req_id", 256'(fetch_mem_req_entry_id), 256'(r.id));
            end
        end
        if (rst_n && refill_vld && refill_rdy) begin
            if (refill_q.size() == 0) begin
                check_eq("refill_unexpected", 256'(refill_q.size()), 256'(1));
            end else begin
                refill_t f;
                f = refill_q.pop_front();
                check_eq("refill_data", refill_data, f.data);
                check_eq("refill_id", 256'(refill_id), 256'(f.id));
            end
        end
        if (rst_n && err_unexp_ack) err_seen++;
    end

    // Called at posedge+1; returns at posedge+1 after the miss is accepted.
    task automatic send_miss(input logic [31:0] a, input logic [7:0] id);
        int n = 0;
        miss_vld = 1'b1; miss_addr = a; miss_id = id;
        @(negedge clk);
        while (!miss_rdy && n < 50) begin n++; @(negedge clk); end
        check_eq("miss_rdy_wait", 256'(miss_rdy), 256'(1));
        if (miss_rdy) req_q.push_back('{addr: a & 32'hFFFF_FFE0, id: id});
        @(posedge clk); #1;
        miss_vld = 1'b0;
    endtask

    task automatic send_ack(input logic [255:0] d, input logic [7:0] id, input bit matched);
        int n = 0;
        fetch_mem_ack_vld = 1'b1; fetch_mem_ack_data = d; fetch_mem_ack_entry_id = id;
        @(negedge clk);
        while (!fetch_mem_ack_rdy && n < 50) begin n++; @(negedge clk); end
        check_eq("ack_rdy_wait", 256'(fetch_mem_ack_rdy), 256'(1));
        if (matched) refill_q.push_back('{data: d, id: id});
        else err_exp++;
        @(posedge clk); #1;
        fetch_mem_ack_vld = 1'b0;
    endtask

    initial begin
        logic [255:0] dl [8];
        for (int i = 0; i < 8; i++) dl[i] = rand_line();
        rst_n = 1'b0; miss_vld = 1'b0; miss_addr = 32'h0; miss_id = 8'h0;
        fetch_mem_req_rdy = 1'b1; fetch_mem_ack_vld = 1'b0; fetch_mem_ack_data = 256'h0;
        fetch_mem_ack_entry_id = 8'h0; refill_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_vld", 256'(fetch_mem_req_vld), 256'(0));
        check_eq("rst_refill_vld", 256'(refill_vld), 256'(0));
        check_eq("rst_cnt", 256'(outstanding_cnt), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_miss_rdy", 256'(miss_rdy), 256'(1));
        check_eq("post_rst_ack_rdy", 256'(fetch_mem_ack_rdy), 256'(1));

        // Single miss/response round trip.
        send_miss(32'h1000_0013, 8'h05);
        check_eq("single_req_vld", 256'(fetch_mem_req_vld), 256'(1));
        check_eq("single_cnt1", 256'(outstanding_cnt), 256'(1));
        @(posedge clk); #1;
        check_eq("single_req_drop", 256'(fetch_mem_req_vld), 256'(0));
        send_ack(dl[0], 8'h05, 1'b1);
        check_eq("single_refill_vld", 256'(refill_vld), 256'(1));
        check_eq("single_cnt0", 256'(outstanding_cnt), 256'(0));
        @(posedge clk); #1;
        check_eq("single_refill_drop", 256'(refill_vld), 256'(0));

        // Fill the tracker, then free one slot to admit a fifth miss.
        for (int i = 1; i <= 4; i++) send_miss(32'h2000_0000 + 32'(i * 64 + 3), 8'(i));
        check_eq("full_cnt", 256'(outstanding_cnt), 256'(4));
        miss_vld = 1'b1; miss_id = 8'h05; miss_addr = 32'h2000_0155;
        @(negedge clk);
        check_eq("full_miss_rdy", 256'(miss_rdy), 256'(0));
        @(posedge clk); #1;
        fetch_mem_ack_vld = 1'b1; fetch_mem_ack_data = dl[1]; fetch_mem_ack_entry_id = 8'h03;
        @(negedge clk);
        check_eq("full_ack_rdy", 256'(fetch_mem_ack_rdy), 256'(1));
        check_eq("full_miss_rdy_same", 256'(miss_rdy), 256'(0));
        refill_q.push_back('{data: dl[1], id: 8'h03});
        @(posedge clk); #1;
        fetch_mem_ack_vld = 1'b0;
        @(negedge clk);
        check_eq("fifth_miss_rdy", 256'(miss_rdy), 256'(1));
        req_q.push_back('{addr: 32'h2000_0140, id: 8'h05});
        @(posedge clk); #1;
        miss_vld = 1'b0;
        check_eq("fifth_cnt", 256'(outstanding_cnt), 256'(4));

        // Out-of-order responses.
        send_ack(dl[2], 8'h04, 1'b1);
        send_ack(dl[3], 8'h01, 1'b1);
        send_ack(dl[4], 8'h05, 1'b1);
        send_ack(dl[5], 8'h02, 1'b1);
        @(posedge clk); #1;
        check_eq("ooo_cnt", 256'(outstanding_cnt), 256'(0));
        check_eq("ooo_no_err", 256'(err_seen), 256'(err_exp));

        // Memory backpressure, then refill backpressure.
        fetch_mem_req_rdy = 1'b0;
        send_miss(32'h3000_0047, 8'h09);
        miss_vld = 1'b1; miss_id = 8'h0A; miss_addr = 32'h3000_009F;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_req_vld", 256'(fetch_mem_req_vld), 256'(1));
            check_eq("stall_req_addr", 256'(fetch_mem_req_addr), 256'(32'h3000_0040));
            check_eq("stall_req_id", 256'(fetch_mem_req_entry_id), 256'(8'h09));
            check_eq("stall_miss_rdy", 256'(miss_rdy), 256'(0));
        end
        @(posedge clk); #1;
        fetch_mem_req_rdy = 1'b1;
        @(negedge clk);
        check_eq("unstall_miss_rdy", 256'(miss_rdy), 256'(1));
        req_q.push_back('{addr: 32'h3000_0080, id: 8'h0A});
        @(posedge clk); #1;
        miss_vld = 1'b0;
        refill_rdy = 1'b0;
        send_ack(dl[6], 8'h09, 1'b1);
        fetch_mem_ack_vld = 1'b1; fetch_mem_ack_data = dl[7]; fetch_mem_ack_entry_id = 8'h0A;
        repeat (3) begin
            @(negedge clk);
            check_eq("hold_ack_rdy", 256'(fetch_mem_ack_rdy), 256'(0));
            check_eq("hold_refill_vld", 256'(refill_vld), 256'(1));
            check_eq("hold_refill_data", refill_data, dl[6]);
        end
        @(posedge clk); #1;
        refill_rdy = 1'b1;
        @(negedge clk);
        check_eq("release_ack_rdy", 256'(fetch_mem_ack_rdy), 256'(1));
        refill_q.push_back('{data: dl[7], id: 8'h0A});
        @(posedge clk); #1;
        fetch_mem_ack_vld = 1'b0;
        @(posedge clk); #1;
        check_eq("stall_cnt_end", 256'(outstanding_cnt), 256'(0));

        // Unmatched response, duplicate tag, tag reuse.
        send_ack(dl[0], 8'h7F, 1'b0);
        check_eq("unexp_err_hi", 256'(err_unexp_ack), 256'(1));
        check_eq("unexp_no_refill", 256'(refill_vld), 256'(0));
        check_eq("unexp_cnt", 256'(outstanding_cnt), 256'(0));
        @(posedge clk); #1;
        check_eq("unexp_err_lo", 256'(err_unexp_ack), 256'(0));
        send_miss(32'h4000_0000, 8'h22);
        miss_vld = 1'b1; miss_id = 8'h22; miss_addr = 32'h4000_0100;
        @(negedge clk);
        check_eq("dup_miss_rdy", 256'(miss_rdy), 256'(0));
        @(posedge clk); #1;
        miss_vld = 1'b0;
        check_eq("dup_cnt", 256'(outstanding_cnt), 256'(1));
        send_ack(dl[1], 8'h22, 1'b1);
        miss_vld = 1'b1;
        @(negedge clk);
        check_eq("reuse_miss_rdy", 256'(miss_rdy), 256'(1));
        req_q.push_back('{addr: 32'h4000_0100, id: 8'h22});
        @(posedge clk); #1;
        miss_vld = 1'b0;
        send_ack(dl[2], 8'h22, 1'b1);

        // Reset mid-flight with a pending refill.
        for (int i = 0; i < 4; i++) send_miss(32'h5000_0000 + 32'(i * 32), 8'(8'h31 + i));
        refill_rdy = 1'b0;
        send_ack(dl[3], 8'h31, 1'b1);
        check_eq("pre_rst_cnt", 256'(outstanding_cnt), 256'(3));
        check_eq("pre_rst_refill", 256'(refill_vld), 256'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_refill_vld", 256'(refill_vld), 256'(0));
        check_eq("mid_rst_refill_data", refill_data, 256'(0));
        check_eq("mid_rst_req_vld", 256'(fetch_mem_req_vld), 256'(0));
        check_eq("mid_rst_err", 256'(err_unexp_ack), 256'(0));
        check_eq("mid_rst_cnt", 256'(outstanding_cnt), 256'(0));
        refill_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; refill_rdy = 1'b1;
        @(posedge clk); #1;
        send_ack(dl[4], 8'h32, 1'b0);
        check_eq("old_tag_err", 256'(err_unexp_ack), 256'(1));
        repeat (3) @(posedge clk);
        #1;
        check_eq("final_cnt", 256'(outstanding_cnt), 256'(0));
        check_eq("final_err_count", 256'(err_seen), 256'(err_exp));
        check_eq("final_req_q", 256'(req_q.size()), 256'(0));
        check_eq("final_refill_q", 256'(refill_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
